perceptron_learn_ctrl: RTL and testbench
========================================

Name: perceptron_learn_ctrl

Overview:
- Sequencer and weight store wrapped around the weighted_sum_top pipeline of the single-layer perceptron.
- Feeds x/w vectors into weighted_sum_top and consumes its 48-bit sum.
- Applies a threshold activation and, in learning mode, performs the perceptron weight update (w += ±x >> LR_SHIFT) before accepting the next sample.
- One sample in flight at a time; weights held internally as N signed 18-bit values.

Parameters:
N, 2, number of inputs/weights (must match the weighted_sum_top instance)
SUM_LAT, 5, cycles from x_out/w_out first presented to sum_in valid (3+N for weighted_sum_top)
THRESH, 0, signed 48-bit activation threshold; y = (sum > THRESH)
LR_SHIFT, 0, learning-rate right shift (arithmetic) applied to x before update
W_INIT, 0, signed 18-bit reset value of every weight

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to process x_in; honoured only in IDLE
learn_en  in  1  sampled with start; 1 = update weights on error, 0 = inference only
x_in  in  18*N  sample vector, signed 18-bit per lane, lane i at [18i+17:18i]
target  in  1  desired class for sample, sampled with start
x_out  out  18*N  registered x to weighted_sum_top
w_out  out  18*N  registered weights to weighted_sum_top
sum_in  in  48  signed weighted sum from weighted_sum_top
busy  out  1  high while a sample is in flight
y_out  out  1  activation result of last sample
y_valid  out  1  one-cycle pulse when y_out updates
err_out  out  1  y_out != target for last sample, valid with y_valid

Behaviour:
- Reset (async assert, sync deassert at clk): state IDLE, all weights = W_INIT, x_out=0, w_out = {N{W_INIT}}, busy=0, y_out=0, y_valid=0, err_out=0, counter=0.
- States: IDLE -> ISSUE -> WAIT -> UPDATE -> IDLE.
- IDLE: start=1 at edge T latches x_in, target, learn_en; x_out <= x_in, w_out <= current weights; -> ISSUE; busy=1 from T+1.
- ISSUE: x_out/w_out held stable; counter loaded with SUM_LAT-1; -> WAIT.
- WAIT: decrement counter each cycle. When 0, sum_in is sampled at edge T+1+SUM_LAT: y_out <= ($signed(sum_in) > $signed(THRESH)), err_out <= y_out_new ^ target, y_valid <= 1; -> UPDATE.
- UPDATE (cycle T+2+SUM_LAT, y_valid=1 this cycle only): if learn_en_latched && err: for each lane, d_i = x_i >>> LR_SHIFT; w_i <= target ? w_i + d_i : w_i - d_i, computed in 19 bits then reduced to 18 (see optional feature). Weights write at end of UPDATE; w_out also updated. -> IDLE; busy=0 from T+3+SUM_LAT.
- Start-to-start minimum spacing: SUM_LAT+3 cycles.
- x_out/w_out never change outside IDLE->ISSUE and UPDATE edges.
- start while busy: ignored, no queueing, no side effect.
- start in the same cycle busy falls (UPDATE): ignored; accepted only in IDLE.
- Reset mid-operation: in-flight sample discarded, no y_valid, weights return to W_INIT.
- learn_en=0: weights never modified; y/err still reported.
- LR_SHIFT >= 18: d_i is 0 or -1 per sign; behaviour defined by arithmetic shift.

Optional Feature:
PERCEPTRON_WEIGHT_SAT_EN
- Defined: 19-bit update result clamped to [-131072, 131071].
- Undefined: result truncated to low 18 bits (two's-complement wrap). Saves logic.

Test Plan:
- Reset with W_INIT=0, then start x=(10,20), target=1, learn_en=1 -> sum 0, y_valid at start+SUM_LAT+2 with y=0, err=1; next w_out=(10,20).
- Repeat same sample -> sum 500, y=1, err=0, weights unchanged (10,20).
- x=(10,20), target=0, learn_en=1 with weights (10,20) -> y=1, err=1, weights become (0,0); with learn_en=0 -> weights stay (10,20).
- Weight 131071, x=10, target=1, error -> 131071 with PERCEPTRON_WEIGHT_SAT_EN, -131063 without.
- start pulsed every cycle for 20 cycles -> samples accepted only every SUM_LAT+3 cycles; x_out stable while busy.
- rst_n low during WAIT -> busy=0, no y_valid, weights W_INIT immediately (async); next start processes normally.

Source files
------------

// File: rtl/perceptron_learn_ctrl.sv
// Perceptron sequencer and weight store around the weighted_sum_top pipeline.
// Optional PERCEPTRON_WEIGHT_SAT_EN clamps weight updates instead of wrapping them.
module perceptron_learn_ctrl #(
    parameter int                 N        = 2,
    parameter int                 SUM_LAT  = 5,
    parameter logic signed [47:0] THRESH   = 48'sd0,
    parameter int                 LR_SHIFT = 0,
    parameter logic signed [17:0] W_INIT   = 18'sd0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            learn_en,
    input  logic [18*N-1:0] x_in,
    input  logic            target,
    output logic [18*N-1:0] x_out,
    output logic [18*N-1:0] w_out,
    input  logic [47:0]     sum_in,
    output logic            busy,
    output logic            y_out,
    output logic            y_valid,
    output logic            err_out
);

    localparam int CW = (SUM_LAT > 1) ? $clog2(SUM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, UPDATE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [18*N-1:0]   x_q, x_d;
    logic [18*N-1:0]   w_q, w_d;
    logic [18*N-1:0]   w_upd;
    logic              tgt_q, tgt_d;
    logic              learn_q, learn_d;
    logic              y_q, y_d;
    logic              err_q, err_d;
    logic              sum_gt;
    logic signed [17:0] d_lane;
`ifdef PERCEPTRON_WEIGHT_SAT_EN
    logic signed [17:0] w_lane;
    logic signed [18:0] s19;
`endif

    assign sum_gt = $signed(sum_in) > THRESH;

    // Candidate weights for an error-driven update; only committed in UPDATE.
    always_comb begin
        w_upd = w_q;
        for (int i = 0; i < N; i++) begin
            d_lane = $signed(x_q[18*i +: 18]) >>> LR_SHIFT;
`ifdef PERCEPTRON_WEIGHT_SAT_EN
            w_lane = $signed(w_q[18*i +: 18]);
            s19    = tgt_q ? {w_lane[17], w_lane} + {d_lane[17], d_lane}
                           : {w_lane[17], w_lane} - {d_lane[17], d_lane};
            if (s19[18] != s19[17])
                w_upd[18*i +: 18] = s19[18] ? 18'h20000 : 18'h1FFFF;
            else
                w_upd[18*i +: 18] = s19[17:0];
`else
            w_upd[18*i +: 18] = tgt_q ? w_q[18*i +: 18] + d_lane
                                      : w_q[18*i +: 18] - d_lane;
`endif
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        w_d     = w_q;
        tgt_d   = tgt_q;
        learn_d = learn_q;
        y_d     = y_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x_in;
                    tgt_d   = target;
                    learn_d = learn_en;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CW'(SUM_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    y_d     = sum_gt;
                    err_d   = sum_gt ^ tgt_q;
                    state_d = UPDATE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            UPDATE: begin
                if (learn_q && err_q)
                    w_d = w_upd;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the weight store is reset explicitly because the first sample after reset must see W_INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            w_q     <= {N{W_INIT}};
            tgt_q   <= 1'b0;
            learn_q <= 1'b0;
            y_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            w_q     <= w_d;
            tgt_q   <= tgt_d;
            learn_q <= learn_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    assign x_out   = x_q;
    assign w_out   = w_q;
    assign busy    = (state_q != IDLE);
    assign y_valid = (state_q == UPDATE);
    assign y_out   = y_q;
    assign err_out = err_q;

endmodule

// File: tb/tb_perceptron_learn_ctrl.sv
// Self-checking bench for perceptron_learn_ctrl: directed table, start flooding,
// mid-flight reset and randomized samples against a behavioural perceptron model.
module tb_perceptron_learn_ctrl;

    localparam int                 N       = 2;
    localparam int                 SUM_LAT = 5;
    localparam logic signed [47:0] TH1     = 48'sd0;
    localparam logic signed [47:0] TH2     = 48'sd100;
    localparam int                 SH1     = 0;
    localparam int                 SH2     = 19;
    localparam int                 W1      = 0;
    localparam int                 W2      = -5;
`ifdef PERCEPTRON_WEIGHT_SAT_EN
    localparam int                 SATV    = 131071;
`else
    localparam int                 SATV    = -131063;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        learn_en = 1'b0;
    logic        target = 1'b0;
    logic [35:0] x_in = '0;
    logic [35:0] x_out1, w_out1, x_out2, w_out2;
    logic signed [47:0] sum1, sum2, dot1, dot2;
    logic        busy1, y_out1, y_valid1, err1;
    logic        busy2, y_out2, y_valid2, err2;
    int          age1 = 0, age2 = 0;
    int          total = 0, bad = 0;
    int          m1a, m1b, m2a, m2b;

    always #5 clk = ~clk;

    perceptron_learn_ctrl #(.N(N), .SUM_LAT(SUM_LAT), .THRESH(TH1), .LR_SHIFT(SH1), .W_INIT(18'sd0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .learn_en(learn_en), .x_in(x_in), .target(target),
        .x_out(x_out1), .w_out(w_out1), .sum_in(sum1), .busy(busy1), .y_out(y_out1),
        .y_valid(y_valid1), .err_out(err1));

    perceptron_learn_ctrl #(.N(N), .SUM_LAT(SUM_LAT), .THRESH(TH2), .LR_SHIFT(SH2), .W_INIT(-18'sd5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .learn_en(learn_en), .x_in(x_in), .target(target),
        .x_out(x_out2), .w_out(w_out2), .sum_in(sum2), .busy(busy2), .y_out(y_out2),
        .y_valid(y_valid2), .err_out(err2));

    // weighted_sum_top stand-in: the sum is only meaningful SUM_LAT cycles after issue;
    // at any other time it carries a value that flips the activation.
    function automatic logic signed [47:0] dot(input logic [35:0] xv, input logic [35:0] wv);
        longint s;
        s = longint'($signed(xv[17:0])) * longint'($signed(wv[17:0]))
          + longint'($signed(xv[35:18])) * longint'($signed(wv[35:18]));
        return 48'(s);
    endfunction

    assign dot1 = dot(x_out1, w_out1);
    assign dot2 = dot(x_out2, w_out2);
    assign sum1 = (age1 == SUM_LAT) ? dot1 : ((dot1 > TH1) ? TH1 : TH1 + 48'sd1);
    assign sum2 = (age2 == SUM_LAT) ? dot2 : ((dot2 > TH2) ? TH2 : TH2 + 48'sd1);

    always @(posedge clk) begin
        age1 <= busy1 ? age1 + 1 : 0;
        age2 <= busy2 ? age2 + 1 : 0;
    end

    // ---------------- reference model ----------------
    function automatic int floor_shift(input int x, input int sh);
        int p;
        p = 1 << sh;
        return (x >= 0) ? x / p : -((-x + p - 1) / p);
    endfunction

    function automatic int fit18(input int r);
`ifdef PERCEPTRON_WEIGHT_SAT_EN
        if (r > 131071) return 131071;
        if (r < -131072) return -131072;
        return r;
`else
        int u;
        u = r & 32'h3FFFF;
        return (u >= 131072) ? u - 262144 : u;
`endif
    endfunction

    task automatic ref_step(input int sh, input longint th, input int xa, input int xb,
                            input bit t, input bit l, inout int wa, inout int wb,
                            output bit y, output bit e);
        longint s;
        int da, db;
        s = longint'(wa) * longint'(xa) + longint'(wb) * longint'(xb);
        y = (s > th);
        e = (y != t);
        if (l && e) begin
            da = floor_shift(xa, sh);
            db = floor_shift(xb, sh);
            wa = fit18(t ? wa + da : wa - da);
            wb = fit18(t ? wb + db : wb - db);
        end
    endtask

    task automatic model_both(input int xa, input int xb, input bit t, input bit l,
                              output bit y1, output bit e1, output bit y2, output bit e2);
        ref_step(SH1, longint'(TH1), xa, xb, t, l, m1a, m1b, y1, e1);
        ref_step(SH2, longint'(TH2), xa, xb, t, l, m2a, m2b, y2, e2);
    endtask

    task automatic model_reset();
        m1a = W1; m1b = W1; m2a = W2; m2b = W2;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [63:0] lane(input logic [35:0] v, input int i);
        return 64'($signed(v[18*i +: 18]));
    endfunction

    function automatic logic [35:0] pack_x(input int xa, input int xb);
        logic [17:0] a, b;
        a = 18'(xa);
        b = 18'(xb);
        return {b, a};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_sample(input int xa, input int xb, input bit t, input bit l,
                             output logic y1, output logic e1, output logic y2, output logic e2);
        int cyc;
        logic held_ok;
        logic [35:0] xv;
        xv = pack_x(xa, xb);
        held_ok = 1'b1;
        @(negedge clk);
        x_in = xv; target = t; learn_en = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check("busy_after_start", busy1, 1);
        while (!y_valid1 && cyc < 40) begin
            if (x_out1 !== xv || x_out2 !== xv) held_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("y_valid_latency", cyc, SUM_LAT + 2);
        check("y_valid2_aligned", y_valid2, 1);
        check("x_out_held", held_ok, 1);
        y1 = y_out1; e1 = err1; y2 = y_out2; e2 = err2;
        @(negedge clk);
        check("y_valid_single", y_valid1, 0);
        check("busy_cleared", busy1, 0);
    endtask

    task automatic run_and_check(input int xa, input int xb, input bit t, input bit l,
                                 output logic y1, output logic e1);
        bit ey1, ee1, ey2, ee2;
        logic y2, e2;
        model_both(xa, xb, t, l, ey1, ee1, ey2, ee2);
        do_sample(xa, xb, t, l, y1, e1, y2, e2);
        check("y1", y1, ey1);
        check("err1", e1, ee1);
        check("y2", y2, ey2);
        check("err2", e2, ee2);
        check("w1_lane0", lane(w_out1, 0), m1a);
        check("w1_lane1", lane(w_out1, 1), m1b);
        check("w2_lane0", lane(w_out2, 0), m2a);
        check("w2_lane1", lane(w_out2, 1), m2b);
    endtask

    typedef struct {
        bit rst;
        int xa, xb;
        bit t, l;
        bit ey, ee;
        int ewa, ewb;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic y, e;
        logic pb, stable_ok, saw_valid;
        logic [35:0] held;
        bit sy1, se1, sy2, se2;
        int acc[$];
        int xa, xb;

        // rst, xa, xb, target, learn, exp y, exp err, exp w0, exp w1 (instance 1)
        tbl[0] = '{1'b1, 10, 20, 1'b1, 1'b1, 1'b0, 1'b1, 10, 20};
        tbl[1] = '{1'b0, 10, 20, 1'b1, 1'b1, 1'b1, 1'b0, 10, 20};
        tbl[2] = '{1'b0, 10, 20, 1'b0, 1'b0, 1'b1, 1'b1, 10, 20};
        tbl[3] = '{1'b0, 10, 20, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0};
        tbl[4] = '{1'b0, -3, 7, 1'b1, 1'b1, 1'b0, 1'b1, -3, 7};
        tbl[5] = '{1'b0, 5, -2, 1'b0, 1'b1, 1'b0, 1'b0, -3, 7};
        tbl[6] = '{1'b1, 131071, -100, 1'b1, 1'b1, 1'b0, 1'b1, 131071, -100};
        tbl[7] = '{1'b0, 10, 131071, 1'b1, 1'b1, 1'b0, 1'b1, SATV, 130971};

        model_reset();
        repeat (2) @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_y_valid", y_valid1, 0);
        check("rst_y_out", y_out1, 0);
        check("rst_err", err1, 0);
        check("rst_x_out", x_out1, 0);
        check("rst_w1_lane0", lane(w_out1, 0), W1);
        check("rst_w2_lane1", lane(w_out2, 1), W2);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].rst) do_reset();
            run_and_check(tbl[i].xa, tbl[i].xb, tbl[i].t, tbl[i].l, y, e);
            check("tbl_y", y, tbl[i].ey);
            check("tbl_err", e, tbl[i].ee);
            check("tbl_w0", lane(w_out1, 0), tbl[i].ewa);
            check("tbl_w1", lane(w_out1, 1), tbl[i].ewb);
        end

        // start held high for 20 cycles with changing x: only IDLE starts are taken
        do_reset();
        pb = busy1;
        stable_ok = 1'b1;
        held = '0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (busy1 && !pb) begin
                acc.push_back(k - 1);
                held = pack_x(613 * (k - 1) - 5000, 9000 - 1217 * (k - 1));
                model_both(613 * (k - 1) - 5000, 9000 - 1217 * (k - 1), bit'((k - 1) % 2), 1'b1,
                           sy1, se1, sy2, se2);
                if (x_out1 !== held) stable_ok = 1'b0;
            end else if (busy1) begin
                if (x_out1 !== held || x_out2 !== held) stable_ok = 1'b0;
            end
            if (y_valid1) begin
                check("spam_y1", y_out1, sy1);
                check("spam_err1", err1, se1);
                check("spam_y2", y_out2, sy2);
                check("spam_err2", err2, se2);
            end
            pb = busy1;
            if (k < 20) begin
                x_in = pack_x(613 * k - 5000, 9000 - 1217 * k);
                target = bit'(k % 2);
                learn_en = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("spam_accepts", acc.size(), 3);
        for (int i = 0; i < acc.size(); i++) check("spam_accept_cycle", acc[i], i * (SUM_LAT + 3));
        check("spam_x_stable", stable_ok, 1);
        check("spam_w1_lane0", lane(w_out1, 0), m1a);
        check("spam_w1_lane1", lane(w_out1, 1), m1b);
        check("spam_w2_lane0", lane(w_out2, 0), m2a);
        check("spam_w2_lane1", lane(w_out2, 1), m2b);

        for (int i = 0; i < 40; i++) begin
            xa = int'($urandom_range(0, 4000)) - 2000;
            xb = int'($urandom_range(0, 4000)) - 2000;
            run_and_check(xa, xb, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), y, e);
        end

        // reset while waiting for the sum: sample dropped, weights back to W_INIT at once
        run_and_check(300, -400, 1'b1, 1'b1, y, e);
        @(negedge clk);
        x_in = pack_x(700, 900); target = 1'b0; learn_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_busy", busy1, 0);
        check("midrst_y_valid", y_valid1, 0);
        check("midrst_x_out", x_out1, 0);
        check("midrst_w1_lane0", lane(w_out1, 0), W1);
        check("midrst_w1_lane1", lane(w_out1, 1), W1);
        check("midrst_w2_lane0", lane(w_out2, 0), W2);
        saw_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (y_valid1 || y_valid2) saw_valid = 1'b1;
        end
        check("midrst_no_y_valid", saw_valid, 0);
        run_and_check(-50, 60, 1'b1, 1'b1, y, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
